// File: rtl/state_sequence_monitor.sv
// state_sequence_monitor
// Receive-side checker for the IDLE->START->RUN->STOP->IDLE state bus.
// It locks on the first valid IDLE and counts completed rounds. Illegal
// transitions are flagged with a pulse, a sticky bit and a saturating count.
// After an illegal sample it resynchronises on its own.
module state_sequence_monitor #(
  parameter int unsigned COUNT_W    = 16,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned ALLOW_HOLD = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         state_in,
  input  logic               state_valid,
  input  logic               error_clear,
  output logic               locked,
  output logic [1:0]         expected_state,
  output logic               cycle_done,
  output logic [COUNT_W-1:0] cycle_count,
  output logic               error,
  output logic               error_sticky,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10,
    ST_STOP  = 2'b11
  } seq_state_e;

  typedef enum logic {
    MODE_SYNC   = 1'b0,
    MODE_LOCKED = 1'b1
  } mode_e;

  function automatic seq_state_e succ(input seq_state_e s);
    case (s)
      ST_IDLE:  succ = ST_START;
      ST_START: succ = ST_RUN;
      ST_RUN:   succ = ST_STOP;
      default:  succ = ST_IDLE;
    endcase
  endfunction

  mode_e              mode_q, mode_d;
  seq_state_e         prev_q, prev_d;
  logic               locked_q, locked_d;
  seq_state_e         expected_q, expected_d;
  logic               cycle_done_q, cycle_done_d;
  logic [COUNT_W-1:0] cycle_count_q, cycle_count_d;
  logic               error_q, error_d;
  logic               error_sticky_q, error_sticky_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  seq_state_e sample;
  assign sample = seq_state_e'(state_in);

  // Next-state: the clear is applied before any error in the same cycle, so
  // an error that coincides with a clear leaves sticky=1 and count=1.
  always_comb begin
    mode_d         = mode_q;
    prev_d         = prev_q;
    cycle_count_d  = cycle_count_q;
    error_sticky_d = error_sticky_q;
    err_count_d    = err_count_q;
    cycle_done_d   = 1'b0;
    error_d        = 1'b0;

    if (error_clear) begin
      error_sticky_d = 1'b0;
      err_count_d    = '0;
    end

    if (state_valid) begin
      case (mode_q)
        MODE_SYNC: begin
          if (sample == ST_IDLE) begin
            mode_d = MODE_LOCKED;
            prev_d = ST_IDLE;
          end
        end
        default: begin
          if (sample == succ(prev_q)) begin
            prev_d = sample;
            if (sample == ST_IDLE) begin
              cycle_done_d  = 1'b1;
              cycle_count_d = cycle_count_q + COUNT_W'(1);
            end
          end else if ((ALLOW_HOLD != 0) && (sample == prev_q)) begin
            prev_d = prev_q;
          end else begin
            error_d        = 1'b1;
            error_sticky_d = 1'b1;
            if (err_count_d != '1) begin
              err_count_d = err_count_d + ERR_W'(1);
            end
            if (sample == ST_IDLE) begin
              prev_d = ST_IDLE;
            end else begin
              mode_d = MODE_SYNC;
            end
          end
        end
      endcase
    end

    locked_d   = (mode_d == MODE_LOCKED);
    expected_d = (mode_d == MODE_LOCKED) ? succ(prev_d) : ST_IDLE;
  end

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q         <= MODE_SYNC;
      prev_q         <= ST_IDLE;
      locked_q       <= 1'b0;
      expected_q     <= ST_IDLE;
      cycle_done_q   <= 1'b0;
      cycle_count_q  <= '0;
      error_q        <= 1'b0;
      error_sticky_q <= 1'b0;
      err_count_q    <= '0;
    end else begin
      mode_q         <= mode_d;
      prev_q         <= prev_d;
      locked_q       <= locked_d;
      expected_q     <= expected_d;
      cycle_done_q   <= cycle_done_d;
      cycle_count_q  <= cycle_count_d;
      error_q        <= error_d;
      error_sticky_q <= error_sticky_d;
      err_count_q    <= err_count_d;
    end
  end

  assign locked         = locked_q;
  assign expected_state = expected_q;
  assign cycle_done     = cycle_done_q;
  assign cycle_count    = cycle_count_q;
  assign error          = error_q;
  assign error_sticky   = error_sticky_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_state_sequence_monitor.sv
// Directed bench for state_sequence_monitor: three instances share one
// stimulus stream (default, hold-allowed, and narrow 2-bit counters).
module tb_state_sequence_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] state_in;
  logic       state_valid;
  logic       error_clear;

  always #5 clock = ~clock;

  // u0: defaults
  logic        a_locked, a_cd, a_err, a_stk;
  logic [1:0]  a_exp;
  logic [15:0] a_cnt;
  logic [7:0]  a_ecnt;
  // u1: ALLOW_HOLD=1
  logic        b_locked, b_cd, b_err, b_stk;
  logic [1:0]  b_exp;
  logic [15:0] b_cnt;
  logic [7:0]  b_ecnt;
  // u2: COUNT_W=2, ERR_W=2
  logic        c_locked, c_cd, c_err, c_stk;
  logic [1:0]  c_exp;
  logic [1:0]  c_cnt;
  logic [1:0]  c_ecnt;

  state_sequence_monitor u0 (
    .clock(clock), .reset(reset), .state_in(state_in), .state_valid(state_valid),
    .error_clear(error_clear), .locked(a_locked), .expected_state(a_exp),
    .cycle_done(a_cd), .cycle_count(a_cnt), .error(a_err),
    .error_sticky(a_stk), .err_count(a_ecnt));

  state_sequence_monitor #(.ALLOW_HOLD(1)) u1 (
    .clock(clock), .reset(reset), .state_in(state_in), .state_valid(state_valid),
    .error_clear(error_clear), .locked(b_locked), .expected_state(b_exp),
    .cycle_done(b_cd), .cycle_count(b_cnt), .error(b_err),
    .error_sticky(b_stk), .err_count(b_ecnt));

  state_sequence_monitor #(.COUNT_W(2), .ERR_W(2)) u2 (
    .clock(clock), .reset(reset), .state_in(state_in), .state_valid(state_valid),
    .error_clear(error_clear), .locked(c_locked), .expected_state(c_exp),
    .cycle_done(c_cd), .cycle_count(c_cnt), .error(c_err),
    .error_sticky(c_stk), .err_count(c_ecnt));

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [1:0] s, input logic v, input logic clr);
    state_in    = s;
    state_valid = v;
    error_clear = clr;
    @(posedge clock);
    #1;
    chk("excl_a", {31'd0, a_cd & a_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; state_in = 2'b00; state_valid = 1'b0; error_clear = 1'b0;
    step(2'b00, 1'b0, 1'b0);
    chk("rst_locked", {31'd0, a_locked}, 32'd0);
    chk("rst_exp",    {30'd0, a_exp}, 32'd0);
    chk("rst_cd",     {31'd0, a_cd}, 32'd0);
    chk("rst_cnt",    {16'd0, a_cnt}, 32'd0);
    chk("rst_err",    {31'd0, a_err}, 32'd0);
    chk("rst_stk",    {31'd0, a_stk}, 32'd0);
    chk("rst_ecnt",   {24'd0, a_ecnt}, 32'd0);
    reset = 1'b0;

    // Clean round
    step(2'b00, 1'b1, 1'b0);
    chk("lock_first", {31'd0, a_locked}, 32'd1);
    chk("exp_01", {30'd0, a_exp}, 32'h1);
    chk("cd_after_idle", {31'd0, a_cd}, 32'd0);
    step(2'b01, 1'b1, 1'b0); chk("exp_10", {30'd0, a_exp}, 32'h2);
    step(2'b10, 1'b1, 1'b0); chk("exp_11", {30'd0, a_exp}, 32'h3);
    step(2'b11, 1'b1, 1'b0); chk("exp_00", {30'd0, a_exp}, 32'h0);
    step(2'b00, 1'b1, 1'b0);
    chk("round_cd",  {31'd0, a_cd}, 32'd1);
    chk("round_cnt", {16'd0, a_cnt}, 32'd1);
    chk("round_err", {31'd0, a_err}, 32'd0);
    chk("round_exp", {30'd0, a_exp}, 32'h1);
    step(2'b00, 1'b0, 1'b0);
    chk("cd_one_cycle", {31'd0, a_cd}, 32'd0);

    // Non-IDLE error drops lock; non-IDLE samples in SYNC are ignored
    step(2'b01, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0);
    chk("skip_err",    {31'd0, a_err}, 32'd1);
    chk("skip_stk",    {31'd0, a_stk}, 32'd1);
    chk("skip_ecnt",   {24'd0, a_ecnt}, 32'd1);
    chk("skip_locked", {31'd0, a_locked}, 32'd0);
    chk("skip_exp",    {30'd0, a_exp}, 32'h0);
    step(2'b10, 1'b1, 1'b0); chk("sync_ign_10", {31'd0, a_err}, 32'd0);
    step(2'b11, 1'b1, 1'b0); chk("sync_ign_11", {31'd0, a_err}, 32'd0);
    chk("sync_ecnt", {24'd0, a_ecnt}, 32'd1);
    step(2'b00, 1'b1, 1'b0);
    chk("relock",    {31'd0, a_locked}, 32'd1);
    chk("relock_cd", {31'd0, a_cd}, 32'd0);

    // Premature IDLE at prev=RUN: immediate resync, no round counted
    step(2'b01, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    chk("early_err",    {31'd0, a_err}, 32'd1);
    chk("early_locked", {31'd0, a_locked}, 32'd1);
    chk("early_exp",    {30'd0, a_exp}, 32'h1);
    chk("early_cd",     {31'd0, a_cd}, 32'd0);
    chk("early_cnt",    {16'd0, a_cnt}, 32'd1);
    chk("early_ecnt",   {24'd0, a_ecnt}, 32'd2);

    // Repeated state: error without hold, legal with hold
    step(2'b01, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    chk("hold0_err", {31'd0, a_err}, 32'd1);
    chk("hold1_err", {31'd0, b_err}, 32'd0);
    chk("hold1_exp_mid", {30'd0, b_exp}, 32'h2);
    step(2'b10, 1'b1, 1'b0);
    chk("hold1_exp_end", {30'd0, b_exp}, 32'h3);
    chk("hold1_err_end", {31'd0, b_err}, 32'd0);
    chk("hold1_ecnt",    {24'd0, b_ecnt}, 32'd2);
    chk("hold0_ecnt",    {24'd0, a_ecnt}, 32'd3);
    chk("hold0_locked",  {31'd0, a_locked}, 32'd0);

    // Clear coinciding with an illegal sample
    step(2'b00, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1);
    chk("clr_err",  {31'd0, a_err}, 32'd1);
    chk("clr_ecnt", {24'd0, a_ecnt}, 32'd1);
    chk("clr_stk",  {31'd0, a_stk}, 32'd1);
    step(2'b00, 1'b0, 1'b1);
    chk("clr_only_ecnt", {24'd0, a_ecnt}, 32'd0);
    chk("clr_only_stk",  {31'd0, a_stk}, 32'd0);
    chk("clr_keeps_cnt", {16'd0, a_cnt}, 32'd1);

    // Saturation: five IDLE-repeat errors on the 2-bit error counter
    step(2'b00, 1'b1, 1'b0);
    chk("sat_lock", {31'd0, c_locked}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 1'b1, 1'b0);
      chk("sat_pulse", {31'd0, c_err}, 32'd1);
      chk("sat_ecnt",  {30'd0, c_ecnt}, (i < 3) ? 32'(i + 1) : 32'd3);
      chk("wide_ecnt", {24'd0, a_ecnt}, 32'(i + 1));
    end
    step(2'b00, 1'b0, 1'b0);
    chk("sat_pulse_end", {31'd0, c_err}, 32'd0);

    // Wrap: reset, lock, five rounds on the 2-bit cycle counter
    reset = 1'b1;
    step(2'b00, 1'b1, 1'b0);
    reset = 1'b0;
    step(2'b00, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step(2'b01, 1'b1, 1'b0);
      step(2'b10, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b0);
      step(2'b00, 1'b1, 1'b0);
      chk("wrap_cd",   {31'd0, c_cd}, 32'd1);
      chk("wrap_cnt",  {30'd0, c_cnt}, 32'((r + 1) % 4));
      chk("wide_cnt",  {16'd0, a_cnt}, 32'(r + 1));
      chk("wrap_err",  {31'd0, c_err}, 32'd0);
    end

    // Invalid cycles with garbage on the bus
    step(2'b10, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(2'(g + 1), 1'b0, 1'b0);
      chk("hold_locked", {31'd0, a_locked}, 32'd1);
      chk("hold_exp",    {30'd0, a_exp}, 32'h1);
      chk("hold_cnt",    {16'd0, a_cnt}, 32'd5);
      chk("hold_cd",     {31'd0, a_cd}, 32'd0);
      chk("hold_err",    {31'd0, a_err}, 32'd0);
      chk("hold_ecnt",   {24'd0, a_ecnt}, 32'd0);
    end

    // Reset mid-round at prev=RUN
    step(2'b01, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b0);
    reset = 1'b1;
    step(2'b11, 1'b1, 1'b1);
    chk("mid_locked", {31'd0, a_locked}, 32'd0);
    chk("mid_exp",    {30'd0, a_exp}, 32'h0);
    chk("mid_cnt",    {16'd0, a_cnt}, 32'd0);
    chk("mid_cd",     {31'd0, a_cd}, 32'd0);
    chk("mid_err",    {31'd0, a_err}, 32'd0);
    chk("mid_stk",    {31'd0, a_stk}, 32'd0);
    chk("mid_ecnt",   {24'd0, a_ecnt}, 32'd0);
    reset = 1'b0;
    step(2'b11, 1'b1, 1'b0);
    chk("post_rst_ign", {31'd0, a_locked}, 32'd0);
    chk("post_rst_err", {31'd0, a_err}, 32'd0);
    step(2'b00, 1'b1, 1'b0);
    chk("post_rst_lock", {31'd0, a_locked}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
